// File: rtl/data_memory_param_pkg.sv
// Shared definitions for the nRISC data memory and the CPU top that embeds it.
// Holds the clear-sequencer state encoding and default bus widths.
// No logic; pure types and constants.
package data_memory_param_pkg;

  // Encoding is fixed: the CPU top decodes these values directly.
  typedef enum logic {
    MEM_ST_CLEAR = 1'b0,
    MEM_ST_READY = 1'b1
  } mem_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/data_memory_param_if.sv
// Load/store bus between the datapath and the data memory.
// Ports: address/writedata/memwrite driven by master (datapath);
//        data/ready/addr_err driven by slave (memory).
interface data_memory_param_if
  import data_memory_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              memwrite;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              addr_err;

  modport master (
    output address, writedata, memwrite,
    input  data, ready, addr_err
  );

  modport slave (
    input  address, writedata, memwrite,
    output data, ready, addr_err
  );
endinterface

// File: rtl/data_memory_param_mem_clear_seq.sv
// Post-reset clear sequencer: walks ptr over every word index once, then parks in READY.
// Latency: done rises on the DEPTH-th rising edge after reset releases.
// No backpressure: runs freely one word per cycle.
// Ports: clock, reset (async active-low), ptr (word to clear), clr_we (clear write), done.
module mem_clear_seq
  import data_memory_param_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  output logic [PW-1:0] ptr,
  output logic          clr_we,
  output logic          done
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  mem_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      MEM_ST_CLEAR: begin
        clr_we = 1'b1;
        // Hold the pointer on the last word instead of wrapping back to 0.
        if (ptr_q == LAST) state_d = MEM_ST_READY;
        else               ptr_d   = ptr_q + 1'b1;
      end
      default: ;  // READY is terminal until reset
    endcase
  end

  assign ptr  = ptr_q;
  assign done = (state_q == MEM_ST_READY);

endmodule

// File: rtl/data_memory_param.sv
// Word-wide data RAM: combinational read, synchronous write, post-reset clear, range guard.
// Latency: read 0 cycles, write lands on the sampling edge, addr_err 1 cycle after the edge.
// No backpressure: every in-range write is taken; accesses are inert until ready.
// Ports: clock, reset (async active-low), bus (slave side of data_memory_param_if).
module data_memory_param
  import data_memory_param_pkg::*;
#(
  parameter int                 DATA_W   = DEF_DATA_W,
  parameter int                 ADDR_W   = DEF_ADDR_W,
  parameter int                 DEPTH    = 256,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  data_memory_param_if.slave   bus
);

  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  reg [DATA_W-1:0] mem [0:DEPTH-1];

  logic [PW-1:0]     clr_ptr;
  logic              clr_we;
  logic              done;
  logic              in_range;
  logic              port_we;
  logic              we;
  logic [PW-1:0]     waddr;
  logic [DATA_W-1:0] wdat;
  logic              addr_err_q;

  mem_clear_seq #(.DEPTH(DEPTH), .PW(PW)) u_clr (
    .clock  (clock),
    .reset  (reset),
    .ptr    (clr_ptr),
    .clr_we (clr_we),
    .done   (done)
  );

  assign in_range = ({1'b0, bus.address} < DEPTH_X);
  assign port_we  = done && bus.memwrite && in_range;

  // Sequencer owns the write port until it reports done.
  assign we    = clr_we || port_we;
  assign waddr = clr_we ? clr_ptr  : bus.address[PW-1:0];
  assign wdat  = clr_we ? INIT_VAL : bus.writedata;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdat;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) addr_err_q <= 1'b0;
    else        addr_err_q <= done && bus.memwrite && !in_range;
  end

  assign bus.data     = (done && in_range) ? mem[bus.address[PW-1:0]] : '0;
  assign bus.ready    = done;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_data_memory_param.sv
// Self-checking bench for data_memory_param (DEPTH=16, INIT_VAL=8'hA5).
// Reference: an array of words plus the rule "ready after DEPTH edges"; random traffic on top.
module tb_data_memory_param;

  localparam int         DATA_W = 8;
  localparam int         ADDR_W = 8;
  localparam int         DEPTH  = 16;
  localparam logic [7:0] INIT   = 8'hA5;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #10 clock = ~clock;

  data_memory_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_memory_param #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] ref_mem [DEPTH];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] ref_read(input logic [7:0] a);
    return (a < DEPTH) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic w);
    bus.address   = a;
    bus.writedata = d;
    bus.memwrite  = w;
  endtask

  // One READY-state cycle: check the combinational read, clock, then check addr_err.
  task automatic step(input string tag);
    logic err_exp;
    #1;
    check({tag, ".data"}, bus.data, ref_read(bus.address));
    err_exp = bus.memwrite && (bus.address >= DEPTH);
    if (bus.memwrite && bus.address < DEPTH) ref_mem[bus.address[3:0]] = bus.writedata;
    @(posedge clock); #1;
    check({tag, ".addr_err"}, bus.addr_err, err_exp);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a);
    drive(a, 8'h00, 1'b0);
    @(negedge clock);
    check(tag, bus.data, ref_read(a));
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < DEPTH; k++) read_chk(tag, 8'(k));
  endtask

  // Runs n edges of CLEAR with hostile traffic; ready must rise exactly on edge DEPTH.
  task automatic clear_phase(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      if (i == 3) drive(8'd2, 8'h77, 1'b1);
      else        drive(8'($urandom_range(0, 31)), 8'($urandom), 1'b1);
      #1;
      check({tag, ".clr_data"}, bus.data, 8'h00);
      @(posedge clock); #1;
      check({tag, ".ready"}, bus.ready, (i == DEPTH));
      check({tag, ".clr_err"}, bus.addr_err, 1'b0);
    end
    bus.memwrite = 1'b0;
    if (n >= DEPTH) for (int k = 0; k < DEPTH; k++) ref_mem[k] = INIT;
  endtask

  initial begin
    drive(8'd0, 8'h00, 1'b0);
    #25;
    check("rst.ready", bus.ready, 1'b0);
    check("rst.addr_err", bus.addr_err, 1'b0);
    check("rst.data", bus.data, 8'h00);

    // Reset, partial clear, reset again mid-CLEAR: sequencer must restart.
    @(negedge clock) reset = 1'b1;
    clear_phase("clr_part", 5);
    @(negedge clock) reset = 1'b0;
    #1 check("midclr.ready", bus.ready, 1'b0);

    // Full clear (includes the write to address 2 during CLEAR).
    @(negedge clock) reset = 1'b1;
    clear_phase("clr1", DEPTH);
    read_all("init_rd");

    // Directed writes.
    @(posedge clock); #1;
    drive(8'd0, 8'h02, 1'b1); step("wr0");
    drive(8'd1, 8'h0A, 1'b1); step("wr1");
    drive(8'd0, 8'h00, 1'b0); step("idle");
    read_chk("rd0", 8'd0);
    read_chk("rd1", 8'd1);
    read_chk("rd2", 8'd2);

    // Back-to-back writes.
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      drive(8'(3 + i), 8'(8'h10 + i), 1'b1);
      step("b2b");
    end

    // Out-of-range write: one-cycle addr_err, no corruption.
    drive(8'd20, 8'hFF, 1'b1); step("oor");
    drive(8'd20, 8'h00, 1'b0); step("oor_pulse_end");
    drive(8'd200, 8'h00, 1'b0); step("oor_read_only");
    read_all("post_oor");

    // Random traffic, including reads during writes and out-of-range accesses.
    for (int i = 0; i < 300; i++) begin
      drive(8'($urandom_range(0, 31)), 8'($urandom), ($urandom_range(0, 2) != 0));
      step("rnd");
    end
    drive(8'd0, 8'h00, 1'b0); step("rnd_end");
    read_all("post_rnd");

    // Reset while READY: ready drops asynchronously, memory is re-cleared.
    drive(8'd4, 8'h55, 1'b1); step("wr4");
    drive(8'd4, 8'h00, 1'b0);
    @(negedge clock);
    check("rd4_55", bus.data, 8'h55);
    #4 reset = 1'b0;
    #1 check("async.ready", bus.ready, 1'b0);
    check("async.addr_err", bus.addr_err, 1'b0);
    @(negedge clock) reset = 1'b1;
    clear_phase("clr2", DEPTH);
    read_chk("rd4_init", 8'd4);
    read_all("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
